// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the next-PC sequencer.
package pc_seq_pkg;

    localparam int          PC_W    = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD,
        REDIR
    } state_t;

    typedef struct packed {
        logic [PC_W-1:0] seq;
        logic [PC_W-1:0] btgt;
        logic [PC_W-1:0] jtgt;
    } targets_t;

endpackage

// File: rtl/pc_target_calc.sv
// Candidate next-PC values: sequential, branch and jump targets (all mod 2^32).
import pc_seq_pkg::*;

module pc_target_calc (
    input  logic [PC_W-1:0] pc_in,
    input  logic [PC_W-1:0] branch_off,
    input  logic [25:0]     jump_addr,
    output targets_t        tgt
);

    logic [PC_W-1:0] seq;

    assign seq      = pc_in + PC_STEP;
    assign tgt.seq  = seq;
    assign tgt.btgt = seq + (branch_off << 2);
    assign tgt.jtgt = {seq[31:28], jump_addr, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: boot, sequential fetch, stall hold and deferred redirects.
// Optional misaligned-PC trap enabled by defining PC_ALIGN_CHECK_EN.
import pc_seq_pkg::*;

module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BOOT_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0080
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc_in,
    input  logic            stall,
    input  logic            branch_req,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_off,
    input  logic            jump_req,
    input  logic [25:0]     jump_addr,
    output logic [PC_W-1:0] pc_next,
    output logic            pc_valid,
    output logic            flush,
`ifdef PC_ALIGN_CHECK_EN
    output logic            exc_flag,
    output logic [PC_W-1:0] epc,
`endif
    output logic            redirect_pending
);

    localparam int BCW = $clog2(BOOT_CYCLES + 1);

    state_t          state, state_n;
    logic [BCW-1:0]  boot_cnt;
    logic [PC_W-1:0] pend_tgt, pend_tgt_n;
    logic            pend_n, flush_n, redir;
    logic [PC_W-1:0] redir_tgt;
    targets_t        tgt;
`ifdef PC_ALIGN_CHECK_EN
    logic            exc_n;
`endif

    pc_target_calc u_calc (
        .pc_in      (pc_in),
        .branch_off (branch_off),
        .jump_addr  (jump_addr),
        .tgt        (tgt)
    );

    // Jump outranks a taken branch; an untaken branch is just sequential.
    assign redir     = jump_req | (branch_req & branch_taken);
    assign redir_tgt = jump_req ? tgt.jtgt : tgt.btgt;

    always_comb begin
        state_n    = state;
        pc_next    = tgt.seq;
        flush_n    = 1'b0;
        pend_n     = redirect_pending;
        pend_tgt_n = pend_tgt;
`ifdef PC_ALIGN_CHECK_EN
        exc_n      = 1'b0;
`endif
        unique case (state)
            BOOT: begin
                pc_next = RESET_PC;
                if (boot_cnt == BCW'(BOOT_CYCLES - 1)) state_n = RUN;
            end
            RUN, HOLD: begin
                if (stall) begin
                    pc_next = pc_in;
                    state_n = HOLD;
                    if (redir) begin
                        pend_n     = 1'b1;
                        pend_tgt_n = redir_tgt;
                    end
                end else if (state == HOLD && redirect_pending) begin
                    pc_next = pend_tgt;
                    flush_n = 1'b1;
                    pend_n  = 1'b0;
                    state_n = REDIR;
                end else if (redir) begin
                    pc_next = redir_tgt;
                    flush_n = 1'b1;
                    state_n = REDIR;
                end else begin
                    state_n = RUN;
                end
            end
            REDIR: begin
                // The flushed slot: requests here come from a killed instruction.
                if (stall) begin
                    pc_next = pc_in;
                    state_n = HOLD;
                end else begin
                    state_n = RUN;
                end
            end
            default: state_n = BOOT;
        endcase
`ifdef PC_ALIGN_CHECK_EN
        if ((state == RUN || state == HOLD) && pc_valid && pc_in[1:0] != 2'b00) begin
            pc_next = EXC_VECTOR;
            exc_n   = 1'b1;
            flush_n = 1'b1;
            pend_n  = 1'b0;
            state_n = REDIR;
        end
`endif
        if (!reset) pc_next = RESET_PC;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= BOOT;
            boot_cnt         <= '0;
            pc_valid         <= 1'b0;
            flush            <= 1'b0;
            redirect_pending <= 1'b0;
            pend_tgt         <= '0;
`ifdef PC_ALIGN_CHECK_EN
            exc_flag         <= 1'b0;
            epc              <= '0;
`endif
        end else begin
            state            <= state_n;
            if (state == BOOT) boot_cnt <= boot_cnt + BCW'(1);
            pc_valid         <= (state_n != BOOT);
            flush            <= flush_n;
            redirect_pending <= pend_n;
            pend_tgt         <= pend_tgt_n;
`ifdef PC_ALIGN_CHECK_EN
            exc_flag         <= exc_n;
            if (exc_n) epc   <= pc_in;
`endif
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; the PC register is emulated by driving pc_in.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        stall, branch_req, branch_taken, jump_req;
    logic [31:0] branch_off;
    logic [25:0] jump_addr;
    logic [31:0] pc_next;
    logic        pc_valid, flush, redirect_pending;
`ifdef PC_ALIGN_CHECK_EN
    logic        exc_flag;
    logic [31:0] epc;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .pc_in            (pc_in),
        .stall            (stall),
        .branch_req       (branch_req),
        .branch_taken     (branch_taken),
        .branch_off       (branch_off),
        .jump_req         (jump_req),
        .jump_addr        (jump_addr),
        .pc_next          (pc_next),
        .pc_valid         (pc_valid),
        .flush            (flush),
`ifdef PC_ALIGN_CHECK_EN
        .exc_flag         (exc_flag),
        .epc              (epc),
`endif
        .redirect_pending (redirect_pending)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        stall = 0; branch_req = 0; branch_taken = 0; jump_req = 0;
        branch_off = 0; jump_addr = 0;
    endtask

    task automatic do_boot();
        reset = 0; step();
        reset = 1; step(); step();
        pc_in = 32'h0;
    endtask

    task automatic test_reset();
        reset = 0; pc_in = 32'h1234; clear_reqs();
        #1;
        checks++; if (pc_next !== 32'h0) begin failures++; $display("FAIL rst_pcnext got=%h exp=%h", pc_next, 32'h0); end
        step(); step(); step();
        checks++; if (pc_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", pc_valid); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%b exp=0", flush); end
        checks++; if (redirect_pending !== 1'b0) begin failures++; $display("FAIL rst_pend got=%b exp=0", redirect_pending); end
        reset = 1; #1;
        checks++; if (pc_next !== 32'h0 || pc_valid !== 1'b0) begin failures++; $display("FAIL boot0 pc_next=%h valid=%b exp 0/0", pc_next, pc_valid); end
        step();
        checks++; if (pc_next !== 32'h0 || pc_valid !== 1'b0) begin failures++; $display("FAIL boot1 pc_next=%h valid=%b exp 0/0", pc_next, pc_valid); end
        step();
        pc_in = 32'h0; #1;
        checks++; if (pc_valid !== 1'b1) begin failures++; $display("FAIL boot_valid got=%b exp=1", pc_valid); end
        checks++; if (pc_next !== 32'h4) begin failures++; $display("FAIL seq0 got=%h exp=4", pc_next); end
        step(); pc_in = 32'h4; #1;
        checks++; if (pc_next !== 32'h8) begin failures++; $display("FAIL seq4 got=%h exp=8", pc_next); end
        step(); pc_in = 32'h8; #1;
        checks++; if (pc_next !== 32'hC) begin failures++; $display("FAIL seq8 got=%h exp=c", pc_next); end
        step();
    endtask

    task automatic test_branch();
        pc_in = 32'h100; branch_req = 1; branch_taken = 1; branch_off = 32'hFFFF_FFFE; #1;
        checks++; if (pc_next !== 32'h0FC) begin failures++; $display("FAIL br_tgt got=%h exp=fc", pc_next); end
        step();
        pc_in = 32'h0FC; #1;
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL br_flush got=%b exp=1", flush); end
        checks++; if (pc_next !== 32'h100) begin failures++; $display("FAIL br_redir_ignore got=%h exp=100", pc_next); end
        step();
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL br_flush_1cyc got=%b exp=0", flush); end
        pc_in = 32'h100; branch_taken = 0; #1;
        checks++; if (pc_next !== 32'h104) begin failures++; $display("FAIL br_not_taken got=%h exp=104", pc_next); end
        step(); clear_reqs();
    endtask

    task automatic test_jump();
        pc_in = 32'h1000_0000; jump_req = 1; jump_addr = 26'h40;
        branch_req = 1; branch_taken = 1; branch_off = 32'd5; #1;
        checks++; if (pc_next !== 32'h1000_0100) begin failures++; $display("FAIL jmp_prio got=%h exp=10000100", pc_next); end
        step(); clear_reqs();
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL jmp_flush got=%b exp=1", flush); end
        pc_in = 32'h1000_0100; #1;
        checks++; if (pc_next !== 32'h1000_0104) begin failures++; $display("FAIL jmp_after got=%h exp=10000104", pc_next); end
        step();
    endtask

    task automatic test_stall();
        pc_in = 32'h20; stall = 1; jump_req = 1; jump_addr = 26'h10; #1;
        checks++; if (pc_next !== 32'h20) begin failures++; $display("FAIL stall_hold got=%h exp=20", pc_next); end
        step();
        checks++; if (redirect_pending !== 1'b1) begin failures++; $display("FAIL stall_pend got=%b exp=1", redirect_pending); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL stall_noflush got=%b exp=0", flush); end
        // overwrite pending in HOLD: jump 0x20 -> 0x80 beats a taken branch
        jump_addr = 26'h20; branch_req = 1; branch_taken = 1; branch_off = 32'd3; #1;
        checks++; if (pc_next !== 32'h20) begin failures++; $display("FAIL hold_pc got=%h exp=20", pc_next); end
        step(); clear_reqs(); #1;
        checks++; if (pc_next !== 32'h80) begin failures++; $display("FAIL release_tgt got=%h exp=80", pc_next); end
        step();
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL release_flush got=%b exp=1", flush); end
        checks++; if (redirect_pending !== 1'b0) begin failures++; $display("FAIL release_pend got=%b exp=0", redirect_pending); end
        pc_in = 32'h80; stall = 1; #1;
        checks++; if (pc_next !== 32'h80) begin failures++; $display("FAIL redir_stall got=%h exp=80", pc_next); end
        step(); stall = 0; #1;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL hold_flush got=%b exp=0", flush); end
        checks++; if (pc_next !== 32'h84) begin failures++; $display("FAIL hold_seq got=%h exp=84", pc_next); end
        step();
    endtask

    task automatic test_wrap();
        pc_in = 32'hFFFF_FFFC; #1;
        checks++; if (pc_next !== 32'h0) begin failures++; $display("FAIL wrap got=%h exp=0", pc_next); end
        step();
    endtask

    task automatic test_reset_mid();
        pc_in = 32'h200; stall = 1; jump_req = 1; jump_addr = 26'h3;
        step();
        checks++; if (redirect_pending !== 1'b1) begin failures++; $display("FAIL mid_pend got=%b exp=1", redirect_pending); end
        clear_reqs(); #1;
        checks++; if (pc_next !== 32'hC) begin failures++; $display("FAIL mid_tgt got=%h exp=c", pc_next); end
        step();
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL mid_flush got=%b exp=1", flush); end
        reset = 0; stall = 1; jump_req = 1; #1;
        checks++; if (pc_next !== 32'h0) begin failures++; $display("FAIL mid_rst_pc got=%h exp=0", pc_next); end
        step();
        checks++; if (flush !== 1'b0 || redirect_pending !== 1'b0 || pc_valid !== 1'b0)
            begin failures++; $display("FAIL mid_rst_regs flush=%b pend=%b valid=%b exp 0/0/0", flush, redirect_pending, pc_valid); end
        reset = 1; clear_reqs();
        step(); step(); pc_in = 32'h0;
        checks++; if (pc_valid !== 1'b1) begin failures++; $display("FAIL reboot_valid got=%b exp=1", pc_valid); end
        stall = 1; jump_req = 1; jump_addr = 26'h7;
        step();
        reset = 0;
        step();
        checks++; if (redirect_pending !== 1'b0) begin failures++; $display("FAIL hold_rst_pend got=%b exp=0", redirect_pending); end
        clear_reqs();
        do_boot();
    endtask

`ifdef PC_ALIGN_CHECK_EN
    task automatic test_align();
        pc_in = 32'h102; #1;
        checks++; if (pc_next !== 32'h80) begin failures++; $display("FAIL align_vec got=%h exp=80", pc_next); end
        step();
        checks++; if (exc_flag !== 1'b1 || flush !== 1'b1) begin failures++; $display("FAIL align_flags exc=%b flush=%b exp 1/1", exc_flag, flush); end
        checks++; if (epc !== 32'h102) begin failures++; $display("FAIL align_epc got=%h exp=102", epc); end
        pc_in = 32'h80;
        step();
        checks++; if (exc_flag !== 1'b0) begin failures++; $display("FAIL align_exc_1cyc got=%b exp=0", exc_flag); end
    endtask
`endif

    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_stall();
        test_wrap();
        test_reset_mid();
`ifdef PC_ALIGN_CHECK_EN
        test_align();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
